// File: rtl/uart_cmd_wrapper_if.sv
// uart_cmd_wrapper_if: serial pins plus the command/response handshake of the UART front end.
interface uart_cmd_wrapper_if;
   logic        RX;
   logic        TX;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        trmt;
   logic        tx_done;
   modport master (output RX, clr_cmd_rdy, resp, trmt, input TX, cmd, cmd_rdy, tx_done);
   modport slave (input RX, clr_cmd_rdy, resp, trmt, output TX, cmd, cmd_rdy, tx_done);
endinterface

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: UART receiver assembling 2-byte commands plus a 1-byte response transmitter.
module uart_cmd_wrapper #(
   parameter int BAUD_DIV = 5208,
   parameter int TO_BITS  = 30
) (
   input logic               clk,
   input logic               rst_n,
   uart_cmd_wrapper_if.slave bus
);
   localparam int BW = $clog2(BAUD_DIV);
   localparam int TO_CLKS = TO_BITS * BAUD_DIV;
   localparam int TW = $clog2(TO_CLKS);
   localparam logic [BW-1:0] B_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] B_HALF = BW'(BAUD_DIV / 2 - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TO_CLKS - 1);

   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_ERR} rx_state_t;
   typedef enum logic {A_HIGH, A_LOW} asm_state_t;
   typedef enum logic {T_IDLE, T_XMIT} tx_state_t;

   rx_state_t  rx_st, rx_nxt;
   asm_state_t asm_st, asm_nxt;
   tx_state_t  tx_st, tx_nxt;

   logic          rx_s1, rx_s2, rx_s3;
   logic [BW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shft;
   logic          fall, start_edge, rx_hit, half_hit, shift, byte_rdy, frame_err;
   logic [TW-1:0] to_cnt;
   logic          to_hit, cmd_set;
   logic [7:0]    high_byte;
   logic [15:0]   cmd;
   logic          cmd_rdy;
   logic [BW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [9:0]    tx_shft;
   logic          tx_hit, load, tx_end, tx_done;

   assign fall       = rx_s3 & ~rx_s2;
   assign start_edge = (rx_st == R_IDLE) & fall;
   assign rx_hit     = rx_cnt == B_LAST;
   assign half_hit   = rx_cnt == B_HALF;
   // a start edge arriving on the very last timeout clock still counts as in time
   assign to_hit     = (asm_st == A_LOW) & (rx_st == R_IDLE) & (to_cnt == T_LAST) & ~start_edge;
   assign cmd_set    = (asm_st == A_LOW) & byte_rdy;
   assign tx_hit     = tx_cnt == B_LAST;
   assign load       = (tx_st == T_IDLE) & bus.trmt;
   assign tx_end     = (tx_st == T_XMIT) & tx_hit & (tx_bit == 4'd9);

   always_comb begin
      rx_nxt    = rx_st;
      shift     = 1'b0;
      byte_rdy  = 1'b0;
      frame_err = 1'b0;
      case (rx_st)
         R_IDLE:  rx_nxt = fall ? R_START : R_IDLE;
         R_START: rx_nxt = !half_hit ? R_START : rx_s2 ? R_IDLE : R_DATA;
         R_DATA: begin
            shift  = rx_hit;
            rx_nxt = (rx_hit && rx_bit == 3'd7) ? R_STOP : R_DATA;
         end
         R_STOP: begin
            byte_rdy  = rx_hit & rx_s2;
            frame_err = rx_hit & ~rx_s2;
            rx_nxt    = !rx_hit ? R_STOP : rx_s2 ? R_IDLE : R_ERR;
         end
         R_ERR:   rx_nxt = rx_s2 ? R_IDLE : R_ERR;
         default: rx_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      asm_nxt = asm_st == A_HIGH ? (byte_rdy ? A_LOW : A_HIGH)
                                 : ((byte_rdy | frame_err | to_hit) ? A_HIGH : A_LOW);
      tx_nxt  = load ? T_XMIT : tx_end ? T_IDLE : tx_st;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st  <= R_IDLE;
         asm_st <= A_HIGH;
         tx_st  <= T_IDLE;
      end else begin
         rx_st  <= rx_nxt;
         asm_st <= asm_nxt;
         tx_st  <= tx_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {rx_s1, rx_s2, rx_s3} <= 3'b111;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_shft   <= '0;
         to_cnt    <= '0;
         high_byte <= '0;
         cmd       <= '0;
         cmd_rdy   <= 1'b0;
      end else begin
         {rx_s1, rx_s2, rx_s3} <= {bus.RX, rx_s1, rx_s2};
         rx_cnt    <= (rx_st == R_IDLE || rx_nxt != rx_st || rx_hit) ? '0 : rx_cnt + 1'b1;
         rx_bit    <= (rx_st != R_DATA) ? '0 : shift ? rx_bit + 1'b1 : rx_bit;
         rx_shft   <= shift ? {rx_s2, rx_shft[7:1]} : rx_shft;
         to_cnt    <= (asm_st != A_LOW || rx_st != R_IDLE) ? '0 : to_cnt + 1'b1;
         high_byte <= (asm_st == A_HIGH && byte_rdy) ? rx_shft : high_byte;
         cmd       <= cmd_set ? {high_byte, rx_shft} : cmd;
         cmd_rdy   <= cmd_set ? 1'b1
                    : (bus.clr_cmd_rdy || (start_edge && asm_st == A_HIGH)) ? 1'b0 : cmd_rdy;
      end
   end

   // shifter refills with ones so TX returns to idle high once the stop bit is out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_cnt  <= '0;
         tx_bit  <= '0;
         tx_shft <= 10'h3FF;
         tx_done <= 1'b0;
      end else begin
         tx_cnt  <= (tx_st == T_IDLE || tx_hit) ? '0 : tx_cnt + 1'b1;
         tx_bit  <= (tx_st == T_IDLE) ? '0 : tx_hit ? tx_bit + 1'b1 : tx_bit;
         tx_shft <= load ? {1'b1, bus.resp, 1'b0}
                  : (tx_st == T_XMIT && tx_hit) ? {1'b1, tx_shft[9:1]} : tx_shft;
         tx_done <= load ? 1'b0 : tx_end ? 1'b1 : tx_done;
      end
   end

   assign bus.TX      = tx_shft[0];
   assign bus.cmd     = cmd;
   assign bus.cmd_rdy = cmd_rdy;
   assign bus.tx_done = tx_done;
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb_uart_cmd_wrapper: random command frames and responses checked against a frame-level model.
module tb_uart_cmd_wrapper;
   localparam int BD = 16;
   localparam int TO = 30;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   logic [15:0] m_cmd = '0;
   logic        m_rdy = 1'b0;
   logic        m_pend = 1'b0;
   logic [7:0]  m_hi = '0;

   uart_cmd_wrapper_if bus();
   uart_cmd_wrapper #(.BAUD_DIV(BD), .TO_BITS(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clr();
      bus.clr_cmd_rdy = 1'b1;
      clks(1);
      bus.clr_cmd_rdy = 1'b0;
      m_rdy = 1'b0;
      chk("clr_rdy", 32'(bus.cmd_rdy), 32'(m_rdy));
      chk("clr_cmd_hold", 32'(bus.cmd), 32'(m_cmd));
   endtask

   // gap: idle bit periods before the start bit; hold_clr keeps clr_cmd_rdy high across the set
   task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap, input logic hold_clr);
      int n;
      clks(gap * BD);
      if (gap > TO) m_pend = 1'b0;
      if (!m_pend) m_rdy = 1'b0;
      bus.RX = 1'b0;
      clks(BD);
      for (int i = 0; i < 8; i++) begin
         bus.RX = b[i];
         clks(BD);
      end
      bus.RX = stop_ok;
      if (hold_clr) begin
         bus.clr_cmd_rdy = 1'b1;
         n = 0;
         while (!bus.cmd_rdy && n < BD) begin
            clks(1);
            n++;
         end
         bus.clr_cmd_rdy = 1'b0;
         chk("set_wins_seen", 32'(n < BD), 32'd1);
         clks(BD - n);
      end else begin
         clks(4);
         chk("rdy_mid_stop", 32'(bus.cmd_rdy), 32'(m_rdy));
         clks(BD - 4);
      end
      if (!stop_ok) m_pend = 1'b0;
      else if (!m_pend) begin
         m_pend = 1'b1;
         m_hi = b;
      end else begin
         m_cmd = {m_hi, b};
         m_rdy = 1'b1;
         m_pend = 1'b0;
      end
      bus.RX = 1'b1;
      chk("cmd", 32'(bus.cmd), 32'(m_cmd));
      chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(m_rdy));
   endtask

   task automatic tx_frame(input logic [7:0] r, input logic dup);
      logic [9:0] f;
      f = {1'b1, r, 1'b0};
      bus.resp = r;
      bus.trmt = 1'b1;
      for (int j = 1; j <= 161; j++) begin
         clks(1);
         bus.trmt = dup && j == 50;
         if (dup && j == 50) bus.resp = ~r;
         if (j == 1) chk("tx_done_clr", 32'(bus.tx_done), 32'd0);
         if (j % BD == BD / 2) chk("tx_bit", 32'(bus.TX), 32'(f[(j - 1) / BD]));
         if (j == 160) chk("tx_done_early", 32'(bus.tx_done), 32'd0);
         if (j == 161) begin
            chk("tx_done", 32'(bus.tx_done), 32'd1);
            chk("tx_idle", 32'(bus.TX), 32'd1);
         end
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int r, g;
      bus.RX = 1'b1;
      bus.clr_cmd_rdy = 1'b0;
      bus.resp = '0;
      bus.trmt = 1'b0;
      clks(3);
      chk("rst_tx", 32'(bus.TX), 32'd1);
      chk("rst_cmd", 32'(bus.cmd), 32'd0);
      chk("rst_rdy", 32'(bus.cmd_rdy), 32'd0);
      chk("rst_done", 32'(bus.tx_done), 32'd0);
      rst_n = 1'b1;
      clks(2);

      send_byte(8'h40, 1'b1, 2, 1'b0);
      send_byte(8'h01, 1'b1, 1, 1'b0);
      pulse_clr();

      tx_frame(8'hA5, 1'b1);
      tx_frame(8'h3C, 1'b0);

      send_byte(8'h40, 1'b0, 2, 1'b0);
      send_byte(8'h01, 1'b1, 1, 1'b0);
      send_byte(8'h02, 1'b1, 1, 1'b0);

      send_byte(8'h33, 1'b1, 2, 1'b0);
      send_byte(8'h44, 1'b1, 31, 1'b0);
      send_byte(8'h55, 1'b1, 1, 1'b0);

      send_byte(8'hC3, 1'b1, 2, 1'b0);
      send_byte(8'h3C, 1'b1, 1, 1'b1);

      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 2) pulse_clr();
         g = (r == 1) ? 31 + int'($urandom_range(0, 2)) : int'($urandom_range(1, 4));
         send_byte(8'($urandom), r != 0, g, 1'b0);
      end

      fork
         tx_frame(8'($urandom), 1'b0);
         begin
            send_byte(8'($urandom), 1'b1, 1, 1'b0);
            send_byte(8'($urandom), 1'b1, 1, 1'b0);
            send_byte(8'($urandom), 1'b1, 1, 1'b0);
         end
      join

      bus.resp = 8'h00;
      bus.trmt = 1'b1;
      clks(1);
      bus.trmt = 1'b0;
      bus.RX = 1'b0;
      clks(40);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", 32'(bus.TX), 32'd1);
      chk("mid_rst_rdy", 32'(bus.cmd_rdy), 32'd0);
      chk("mid_rst_cmd", 32'(bus.cmd), 32'd0);
      m_cmd = '0;
      m_rdy = 1'b0;
      m_pend = 1'b0;
      clks(3);
      bus.RX = 1'b1;
      clks(3);
      rst_n = 1'b1;
      send_byte(8'h12, 1'b1, 1, 1'b0);
      send_byte(8'h34, 1'b1, 1, 1'b0);
      chk("post_rst_cmd", 32'(bus.cmd), 32'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
